// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg : shared CPU/memory types (word, RAM state, arbiter kind)
// Rev 1.0
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        INSTR  = 2'd0,
        DREAD  = 2'd1,
        DWRITE = 2'd2
    } arb_kind_t;

    // Index width for a CPU count, never narrower than one bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : cache-side request/wait bus plus single-port RAM bus
// Rev 1.0
// ============================================================================
interface mem_arbiter_if
    import cpu_types_pkg::*;
#(
    parameter int CPUS = 2
);
    logic [CPUS-1:0] iREN;
    word_t [CPUS-1:0] iaddr;
    logic [CPUS-1:0] dREN;
    logic [CPUS-1:0] dWEN;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic [CPUS-1:0] iwait;
    logic [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic bus_err;
    logic busy;

    // Arbiter side
    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               bus_err, busy
    );

    // Caches + RAM side
    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
               bus_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : first set request bit scanning upward from ptr, wrapping
// Rev 1.0
// ============================================================================
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter int PTR_W = ptr_width(CPUS)
) (
    input  logic [CPUS-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] index
);

    int w_slot;

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_slot = 0;
        for (int i = 0; i < CPUS; i++) begin
            w_slot = (int'(ptr) + i) % CPUS;
            if (!valid && req[w_slot]) begin
                valid = 1'b1;
                index = PTR_W'(w_slot);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : serializes per-CPU icache/dcache requests onto one RAM port
// Rev 1.0
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);

    localparam int PTR_W = ptr_width(CPUS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(CPUS - 1);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_owner;
    arb_kind_t        r_kind;
    word_t            r_ramaddr;
    word_t            r_ramstore;
    logic             r_ramREN;
    logic             r_ramWEN;
    logic [CNT_W-1:0] r_count;

    logic [CPUS-1:0]  w_dreq;
    logic             w_dvalid;
    logic             w_ivalid;
    logic [PTR_W-1:0] w_didx;
    logic [PTR_W-1:0] w_iidx;
    logic             w_grant;
    logic [PTR_W-1:0] w_pick;
    arb_kind_t        w_pick_kind;
    word_t            w_pick_addr;
    word_t            w_pick_store;

    logic             w_access;
    logic             w_error;
    logic             w_timeout;
    logic [CPUS-1:0]  w_iwait;
    logic [CPUS-1:0]  w_dwait;
    logic             w_bus_err;

    assign w_dreq = bus.dREN | bus.dWEN;

    rr_pick #(.CPUS(CPUS), .PTR_W(PTR_W)) u_dpick (
        .req   (w_dreq),
        .ptr   (r_rr_ptr),
        .valid (w_dvalid),
        .index (w_didx)
    );

    rr_pick #(.CPUS(CPUS), .PTR_W(PTR_W)) u_ipick (
        .req   (bus.iREN),
        .ptr   (r_rr_ptr),
        .valid (w_ivalid),
        .index (w_iidx)
    );

    // Instruction fetches only win when no data request is pending anywhere
    always_comb begin
        w_grant      = w_dvalid | w_ivalid;
        w_pick       = w_iidx;
        w_pick_kind  = INSTR;
        w_pick_addr  = bus.iaddr[w_iidx];
        w_pick_store = '0;
        if (w_dvalid) begin
            w_pick      = w_didx;
            w_pick_addr = bus.daddr[w_didx];
            if (bus.dWEN[w_didx]) begin
                w_pick_kind  = DWRITE;
                w_pick_store = bus.dstore[w_didx];
            end else begin
                w_pick_kind  = DREAD;
            end
        end
    end

    assign w_access  = (bus.ramstate == ACCESS);
    assign w_error   = (bus.ramstate == ERROR);
    assign w_timeout = (r_count == C_CNT_MAX);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_iwait   = '1;
        w_dwait   = '1;
        w_bus_err = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant) begin
                    w_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (w_error || w_access || w_timeout) begin
                    w_next = ARB_DONE;
                    if (r_kind == INSTR) begin
                        w_iwait[r_owner] = 1'b0;
                    end else begin
                        w_dwait[r_owner] = 1'b0;
                    end
                    // A RAM completion on the final count is still a success
                    w_bus_err = w_error | (w_timeout & ~w_access);
                end
            end
            ARB_DONE: begin
                w_next = ARB_IDLE;
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_kind     <= INSTR;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_owner    <= w_pick;
                        r_kind     <= w_pick_kind;
                        r_ramaddr  <= w_pick_addr;
                        r_ramstore <= w_pick_store;
                        r_ramREN   <= (w_pick_kind != DWRITE);
                        r_ramWEN   <= (w_pick_kind == DWRITE);
                        r_count    <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (w_next == ARB_DONE) begin
                        r_ramREN <= 1'b0;
                        r_ramWEN <= 1'b0;
                    end
                    if (!w_timeout) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ARB_DONE: begin
                    r_count  <= '0;
                    r_rr_ptr <= (r_owner == C_PTR_LAST) ? '0 : r_owner + 1'b1;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.iwait    = w_iwait;
    assign bus.dwait    = w_dwait;
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};
    assign bus.ramREN   = r_ramREN;
    assign bus.ramWEN   = r_ramWEN;
    assign bus.ramaddr  = r_ramaddr;
    assign bus.ramstore = r_ramstore;
    assign bus.bus_err  = w_bus_err;
    assign bus.busy     = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   errors;
    int   checks;

    mem_arbiter_if #(.CPUS(2)) bus ();

    mem_arbiter #(.CPUS(2), .TIMEOUT(255)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_requests();
        bus.iREN = '0;
        bus.dREN = '0;
        bus.dWEN = '0;
    endtask

    task automatic test_reset();
        nRST = 1'b1;
        #2 nRST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if ({bus.ramREN, bus.ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {bus.ramREN, bus.ramWEN}); end
        checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr: got %h want 0", bus.ramaddr); end
        checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore: got %h want 0", bus.ramstore); end
        checks++; if ({bus.iwait, bus.dwait} !== 4'b1111) begin errors++; $display("FAIL reset_waits: got %b want 1111", {bus.iwait, bus.dwait}); end
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus.bus_err); end
        nRST = 1'b1;
    endtask

    task automatic test_instr_read();
        @(negedge CLK);
        bus.iREN[0] = 1'b1;
        bus.iaddr[0] = 32'h40;
        bus.ramstate = BUSY;
        @(negedge CLK);
        checks++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL ifetch_strobe1: got REN=%b WEN=%b want 1 0", bus.ramREN, bus.ramWEN); end
        checks++; if (bus.ramaddr !== 32'h40) begin errors++; $display("FAIL ifetch_addr: got %h want 00000040", bus.ramaddr); end
        checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL ifetch_wait_held: got %b want 11", bus.iwait); end
        @(negedge CLK);
        checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL ifetch_strobe2: got %b want 1", bus.ramREN); end
        bus.ramstate = ACCESS;
        bus.ramload = 32'hDEADBEEF;
        #1;
        checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL ifetch_wait_pulse: got %b want 10", bus.iwait); end
        checks++; if (bus.iload[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL ifetch_iload: got %h want deadbeef", bus.iload[0]); end
        bus.iREN[0] = 1'b0;
        @(negedge CLK);
        bus.ramstate = FREE;
        checks++; if (bus.ramREN !== 1'b0 || bus.iwait !== 2'b11 || bus.busy !== 1'b1) begin errors++; $display("FAIL ifetch_done: got REN=%b iwait=%b busy=%b want 0 11 1", bus.ramREN, bus.iwait, bus.busy); end
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ifetch_idle: got busy=%b want 0", bus.busy); end
    endtask

    // rr_ptr is 1 here; a CPU1 write must still beat the CPU0 fetch on kind alone
    task automatic test_data_priority();
        bus.iREN[0] = 1'b1;
        bus.iaddr[0] = 32'h100;
        bus.dWEN[1] = 1'b1;
        bus.daddr[1] = 32'h80;
        bus.dstore[1] = 32'h1234;
        bus.ramstate = BUSY;
        @(negedge CLK);
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL prio_write_strobe: got WEN=%b REN=%b want 1 0", bus.ramWEN, bus.ramREN); end
        checks++; if (bus.ramaddr !== 32'h80 || bus.ramstore !== 32'h1234) begin errors++; $display("FAIL prio_write_bus: got addr=%h store=%h want 80 1234", bus.ramaddr, bus.ramstore); end
        bus.ramstate = ACCESS;
        #1;
        checks++; if (bus.dwait !== 2'b01 || bus.iwait !== 2'b11) begin errors++; $display("FAIL prio_write_wait: got dwait=%b iwait=%b want 01 11", bus.dwait, bus.iwait); end
        bus.dWEN[1] = 1'b0;
        @(negedge CLK);
        bus.ramstate = BUSY;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100 || bus.ramstore !== 32'h0) begin errors++; $display("FAIL prio_fetch_next: got REN=%b addr=%h store=%h want 1 100 0", bus.ramREN, bus.ramaddr, bus.ramstore); end
        bus.ramstate = ACCESS;
        #1;
        checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL prio_fetch_wait: got %b want 10", bus.iwait); end
        bus.iREN[0] = 1'b0;
        @(negedge CLK);
        bus.ramstate = FREE;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_wait;
        word_t      exp_addr;
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        bus.dREN = 2'b11;
        bus.daddr[0] = 32'h200;
        bus.daddr[1] = 32'h300;
        bus.ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            exp_wait = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (k % 2 == 0) ? 32'h200 : 32'h300;
            bus.ramload = 32'hA000_0000 + k;
            @(negedge CLK);
            checks++; if (bus.dwait !== exp_wait || bus.ramaddr !== exp_addr) begin errors++; $display("FAIL rr_grant%0d: got dwait=%b addr=%h want %b %h", k, bus.dwait, bus.ramaddr, exp_wait, exp_addr); end
            checks++; if (bus.dload[k % 2] !== 32'hA000_0000 + k) begin errors++; $display("FAIL rr_dload%0d: got %h want %h", k, bus.dload[k % 2], 32'hA000_0000 + k); end
            @(negedge CLK);
            checks++; if (bus.dwait !== 2'b11 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL rr_pulse_width%0d: got dwait=%b REN=%b want 11 0", k, bus.dwait, bus.ramREN); end
            if (k == 3) bus.dREN = 2'b00;
            @(negedge CLK);
        end
        bus.ramstate = FREE;
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        bus.dREN[0] = 1'b1;
        bus.daddr[0] = 32'h500;
        bus.ramstate = BUSY;
        for (int c = 0; c < 255; c++) begin
            @(negedge CLK);
            if (bus.dwait !== 2'b11 || bus.bus_err !== 1'b0) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL timeout_early: got %0d early completions want 0", early); end
        @(negedge CLK);
        checks++; if (bus.dwait !== 2'b10 || bus.bus_err !== 1'b1) begin errors++; $display("FAIL timeout_fire: got dwait=%b err=%b want 10 1", bus.dwait, bus.bus_err); end
        bus.dREN[0] = 1'b0;
        @(negedge CLK);
        checks++; if (bus.bus_err !== 1'b0 || bus.ramREN !== 1'b0 || bus.dwait !== 2'b11) begin errors++; $display("FAIL timeout_done: got err=%b REN=%b dwait=%b want 0 0 11", bus.bus_err, bus.ramREN, bus.dwait); end
        bus.ramstate = FREE;
        @(negedge CLK);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_error();
        bus.dREN[0] = 1'b1;
        bus.daddr[0] = 32'h600;
        bus.ramstate = BUSY;
        @(negedge CLK);
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h600) begin errors++; $display("FAIL error_start: got REN=%b addr=%h want 1 600", bus.ramREN, bus.ramaddr); end
        bus.ramstate = ERROR;
        #1;
        checks++; if (bus.dwait !== 2'b10 || bus.bus_err !== 1'b1) begin errors++; $display("FAIL error_pulse: got dwait=%b err=%b want 10 1", bus.dwait, bus.bus_err); end
        bus.dREN[0] = 1'b0;
        @(negedge CLK);
        bus.ramstate = FREE;
        checks++; if ({bus.ramREN, bus.ramWEN, bus.bus_err} !== 3'b000) begin errors++; $display("FAIL error_done: got REN/WEN/err=%b want 000", {bus.ramREN, bus.ramWEN, bus.bus_err}); end
        @(negedge CLK);
        checks++; if ({bus.ramREN, bus.ramWEN, bus.busy} !== 3'b000) begin errors++; $display("FAIL error_idle: got REN/WEN/busy=%b want 000", {bus.ramREN, bus.ramWEN, bus.busy}); end
    endtask

    // rr_ptr is 1 going in, so CPU1 wins first; after reset CPU0 must win
    task automatic test_async_reset();
        bus.iREN = 2'b11;
        bus.iaddr[0] = 32'h740;
        bus.iaddr[1] = 32'h700;
        bus.ramstate = BUSY;
        @(negedge CLK);
        #1;
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h700) begin errors++; $display("FAIL arst_pre: got REN=%b addr=%h want 1 700", bus.ramREN, bus.ramaddr); end
        nRST = 1'b0;
        #1;
        checks++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin errors++; $display("FAIL arst_strobes: got REN=%b WEN=%b want 0 0", bus.ramREN, bus.ramWEN); end
        checks++; if (bus.iwait !== 2'b11 || bus.busy !== 1'b0) begin errors++; $display("FAIL arst_state: got iwait=%b busy=%b want 11 0", bus.iwait, bus.busy); end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        checks++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h740) begin errors++; $display("FAIL arst_rearb: got REN=%b addr=%h want 1 740", bus.ramREN, bus.ramaddr); end
        bus.ramstate = ACCESS;
        #1;
        checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL arst_wait: got %b want 10", bus.iwait); end
        bus.iREN = 2'b00;
        @(negedge CLK);
        bus.ramstate = FREE;
        @(negedge CLK);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        nRST = 1'b1;
        clear_requests();
        bus.iaddr = '0;
        bus.daddr = '0;
        bus.dstore = '0;
        bus.ramload = '0;
        bus.ramstate = FREE;

        test_reset();
        test_instr_read();
        test_data_priority();
        test_round_robin();
        test_timeout();
        test_error();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
